// File: rtl/sha1_stream_ctrl.sv
// rtl/sha1_stream_ctrl.sv - SHA-1 word-stream packer, padder and core sequencer
module sha1_stream_ctrl #(
  parameter int BlockWidth  = 512,
  parameter int DigestWidth = 160,
  parameter int LenWidth    = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            in_data_i,
  input  logic [1:0]             in_nbytes_i,
  input  logic                   in_last_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [BlockWidth-1:0]  block_o,
  output logic                   enable_hash_o,
  output logic                   rst_hash_o,
  output logic                   last_block_o,
  input  logic                   hold_i,
  input  logic                   idle_i,
  input  logic [DigestWidth-1:0] digest_i,
  input  logic                   digest_valid_i,
  output logic [DigestWidth-1:0] digest_o,
  output logic                   digest_valid_o,
  input  logic                   digest_ready_i,
  output logic                   busy_o
);

  localparam logic [8:0] TopBit = 9'(BlockWidth - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FILL,
    S_ISSUE,
    S_WAIT,
    S_DIGEST
  } state_e;

  state_e                 state_q, state_d;
  logic [BlockWidth-1:0]  blk_q, blk_d;
  logic [3:0]             widx_q, widx_d;
  logic [LenWidth-1:0]    bitlen_q, bitlen_d;
  logic                   last_q, last_d;
  logic                   pend_len_q, pend_len_d;
  logic                   pend_80_q, pend_80_d;
  logic                   skip_q, skip_d;
  logic [DigestWidth-1:0] dig_q, dig_d;
  logic                   dvalid_q, dvalid_d;

  logic [2:0]  nb;          // valid bytes in the incoming word, 1..4
  logic [31:0] keep_mask;   // clears bytes past nb in a last word
  logic [6:0]  nbytes_blk;  // bytes in the block once this word lands, 1..64
  logic [8:0]  word_base;   // MSB of word slot widx_q
  logic [8:0]  pad_base;    // MSB of the byte right after the message

  // Per-word byte count, keep mask and insertion positions
  always_comb begin
    nb = (in_last_i && (in_nbytes_i != 2'd0)) ? {1'b0, in_nbytes_i} : 3'd4;
    case (nb)
      3'd1:    keep_mask = 32'hFF00_0000;
      3'd2:    keep_mask = 32'hFFFF_0000;
      3'd3:    keep_mask = 32'hFFFF_FF00;
      default: keep_mask = 32'hFFFF_FFFF;
    endcase
    nbytes_blk = {1'b0, widx_q, 2'b00} + {4'b0000, nb};
    word_base  = TopBit - {widx_q, 5'd0};
    pad_base   = TopBit - {nbytes_blk[5:0], 3'd0};
  end

  // State and datapath registers; reset aborts any message in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      blk_q      <= '0;
      widx_q     <= '0;
      bitlen_q   <= '0;
      last_q     <= 1'b0;
      pend_len_q <= 1'b0;
      pend_80_q  <= 1'b0;
      skip_q     <= 1'b0;
      dig_q      <= '0;
      dvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      widx_q     <= widx_d;
      bitlen_q   <= bitlen_d;
      last_q     <= last_d;
      pend_len_q <= pend_len_d;
      pend_80_q  <= pend_80_d;
      skip_q     <= skip_d;
      dig_q      <= dig_d;
      dvalid_q   <= dvalid_d;
    end
  end

  // Next-state, block assembly, padding and core handshake pulses
  always_comb begin
    state_d       = state_q;
    blk_d         = blk_q;
    widx_d        = widx_q;
    bitlen_d      = bitlen_q;
    last_d        = last_q;
    pend_len_d    = pend_len_q;
    pend_80_d     = pend_80_q;
    skip_d        = skip_q;
    dig_d         = dig_q;
    dvalid_d      = dvalid_q;
    in_ready_o    = 1'b0;
    enable_hash_o = 1'b0;
    rst_hash_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The first word stays with the source until S_FILL.
        if (in_valid_i) state_d = S_INIT;
      end

      S_INIT: begin
        rst_hash_o = 1'b1;
        blk_d      = '0;
        widx_d     = '0;
        bitlen_d   = '0;
        last_d     = 1'b0;
        pend_len_d = 1'b0;
        pend_80_d  = 1'b0;
        skip_d     = 1'b0;
        state_d    = S_FILL;
      end

      S_FILL: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          blk_d[word_base -: 32] = in_data_i & keep_mask;
          bitlen_d = bitlen_q + LenWidth'({nb, 3'b000});
          widx_d   = widx_q + 4'd1;
          if (in_last_i) begin
            state_d = S_ISSUE;
            if (nbytes_blk <= 7'd55) begin
              // Padding and length both fit in this block.
              blk_d[pad_base -: 8]    = 8'h80;
              blk_d[LenWidth-1:0]     = bitlen_d;
              last_d                  = 1'b1;
            end else if (nbytes_blk <= 7'd63) begin
              // 0x80 fits but the length spills to an extra block.
              blk_d[pad_base -: 8]    = 8'h80;
              pend_len_d              = 1'b1;
            end else begin
              // Block exactly full: extra block carries 0x80 and length.
              pend_len_d              = 1'b1;
              pend_80_d               = 1'b1;
            end
          end else if (widx_q == 4'd15) begin
            state_d    = S_ISSUE;
            last_d     = 1'b0;
            pend_len_d = 1'b0;
          end
        end
      end

      S_ISSUE: begin
        if (idle_i && !hold_i) begin
          enable_hash_o = 1'b1;
          skip_d        = 1'b1;
          state_d       = S_WAIT;
        end
      end

      S_WAIT: begin
        // The core may still look idle on the cycle right after enable.
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (idle_i) begin
          if (last_q) begin
            state_d = S_DIGEST;
          end else if (pend_len_q) begin
            blk_d = '0;
            if (pend_80_q) blk_d[TopBit -: 8] = 8'h80;
            blk_d[LenWidth-1:0] = bitlen_q;
            last_d     = 1'b1;
            pend_len_d = 1'b0;
            pend_80_d  = 1'b0;
            state_d    = S_ISSUE;
          end else begin
            blk_d   = '0;
            widx_d  = '0;
            state_d = S_FILL;
          end
        end
      end

      S_DIGEST: begin
        if (!dvalid_q) begin
          if (digest_valid_i) begin
            dig_d    = digest_i;
            dvalid_d = 1'b1;
          end
        end else if (digest_ready_i) begin
          dvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign last_block_o   = enable_hash_o & last_q;
  assign block_o        = blk_q;
  assign digest_o       = dig_q;
  assign digest_valid_o = dvalid_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule
